// File: rtl/alu_sequencer.sv
// Sequences one ALU operation: drives one-hot strobe + operands for LAT cycles, then captures the 64-bit result.
// Latency: legal op LAT+2 cycles from accept to rsp_valid; illegal op 1 cycle.
// Backpressure: req_ready only in IDLE; result held in RESP until rsp_ready.
module alu_sequencer #(
  parameter int LAT_BASIC = 1,
  parameter int LAT_MUL   = 4,
  parameter int LAT_DIV   = 4
) (
  input  logic        clk,
  input  logic        clr_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [3:0]  req_op,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic        alu_and,
  output logic        alu_or,
  output logic        alu_add,
  output logic        alu_sub,
  output logic        alu_mul,
  output logic        alu_div,
  output logic        alu_shr,
  output logic        alu_shl,
  output logic        alu_ror,
  output logic        alu_rol,
  output logic        alu_neg,
  output logic        alu_not,
  output logic        alu_incpc,
  input  logic [63:0] alu_c,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] z_hi,
  output logic [31:0] z_lo,
  output logic        rsp_err
);

  localparam int LAT_MAX_MD = (LAT_MUL > LAT_DIV) ? LAT_MUL : LAT_DIV;
  localparam int LAT_MAX    = (LAT_BASIC > LAT_MAX_MD) ? LAT_BASIC : LAT_MAX_MD;
  localparam int CW         = $clog2(LAT_MAX) + 1;

  localparam logic [CW-1:0] LOAD_BASIC = CW'(LAT_BASIC - 1);
  localparam logic [CW-1:0] LOAD_MUL   = CW'(LAT_MUL - 1);
  localparam logic [CW-1:0] LOAD_DIV   = CW'(LAT_DIV - 1);

  localparam logic [3:0] OP_MUL   = 4'd4;
  localparam logic [3:0] OP_DIV   = 4'd5;
  localparam logic [3:0] OP_LAST  = 4'd12;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EXEC = 2'd1;
  localparam logic [1:0] CAPT = 2'd2;
  localparam logic [1:0] RESP = 2'd3;

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    op_q;
  logic [31:0]   a_q, b_q;
  logic [31:0]   z_hi_q, z_lo_q;
  logic          err_q;
  logic          accept;
  logic          req_legal;
  logic [CW-1:0] lat_load;
  logic [12:0]   strobe;

  assign accept    = (state_q == IDLE) && req_valid;
  assign req_legal = (req_op <= OP_LAST);

  // Hold count for the incoming opcode (counter is loaded with LAT-1).
  always_comb begin
    lat_load = LOAD_BASIC;
    if (req_op == OP_MUL) lat_load = LOAD_MUL;
    else if (req_op == OP_DIV) lat_load = LOAD_DIV;
  end

  // Next-state and down-counter logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          state_d = req_legal ? EXEC : RESP;
          cnt_d   = lat_load;
        end
      end
      EXEC: begin
        if (cnt_q == '0) state_d = CAPT;
        else             cnt_d   = cnt_q - 1'b1;
      end
      CAPT:    state_d = RESP;
      RESP:    if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and counter registers; reset aborts any operation in flight.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Request latch on accept; result capture on leaving CAPT; illegal ops zero the result.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      op_q   <= '0;
      a_q    <= '0;
      b_q    <= '0;
      z_hi_q <= '0;
      z_lo_q <= '0;
      err_q  <= 1'b0;
    end else if (accept) begin
      op_q <= req_op;
      a_q  <= req_a;
      b_q  <= req_b;
      if (!req_legal) begin
        z_hi_q <= '0;
        z_lo_q <= '0;
        err_q  <= 1'b1;
      end
    end else if (state_q == CAPT) begin
      z_hi_q <= alu_c[63:32];
      z_lo_q <= alu_c[31:0];
      err_q  <= 1'b0;
    end
  end

  // One-hot strobe decode, only ever active in EXEC.
  always_comb begin
    strobe = '0;
    for (int i = 0; i < 13; i++) begin
      strobe[i] = (state_q == EXEC) && (op_q == 4'(i));
    end
  end

  assign {alu_incpc, alu_not, alu_neg, alu_rol, alu_ror, alu_shl, alu_shr,
          alu_div, alu_mul, alu_sub, alu_add, alu_or, alu_and} = strobe;

  assign alu_a     = a_q;
  assign alu_b     = b_q;
  assign req_ready = (state_q == IDLE) && clr_n;
  assign rsp_valid = (state_q == RESP);
  assign z_hi      = z_hi_q;
  assign z_lo      = z_lo_q;
  assign rsp_err   = err_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer with a behavioural ALU that latches its result while strobed.
// Latency: measured in cycles from the accept cycle to the first rsp_valid cycle.
// Backpressure: exercised by holding rsp_ready low while toggling req_* inputs.
module tb_alu_sequencer;

  logic        clk = 1'b0;
  logic        clr_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [3:0]  req_op = '0;
  logic [31:0] req_a = '0, req_b = '0;
  logic [31:0] alu_a, alu_b;
  logic        alu_and, alu_or, alu_add, alu_sub, alu_mul, alu_div, alu_shr;
  logic        alu_shl, alu_ror, alu_rol, alu_neg, alu_not, alu_incpc;
  logic [63:0] alu_c = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] z_hi, z_lo;
  logic        rsp_err;
  logic [12:0] stb;

  int passed = 0;
  int total  = 0;

  alu_sequencer #(.LAT_BASIC(1), .LAT_MUL(4), .LAT_DIV(4)) dut (
    .clk(clk), .clr_n(clr_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_a(req_a), .req_b(req_b), .alu_a(alu_a), .alu_b(alu_b),
    .alu_and(alu_and), .alu_or(alu_or), .alu_add(alu_add), .alu_sub(alu_sub),
    .alu_mul(alu_mul), .alu_div(alu_div), .alu_shr(alu_shr), .alu_shl(alu_shl),
    .alu_ror(alu_ror), .alu_rol(alu_rol), .alu_neg(alu_neg), .alu_not(alu_not),
    .alu_incpc(alu_incpc), .alu_c(alu_c), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .z_hi(z_hi), .z_lo(z_lo), .rsp_err(rsp_err)
  );

  assign stb = {alu_incpc, alu_not, alu_neg, alu_rol, alu_ror, alu_shl, alu_shr,
                alu_div, alu_mul, alu_sub, alu_add, alu_or, alu_and};

  always #5 clk = ~clk;

  // Behavioural ALU: result register updated on every strobed cycle.
  always @(posedge clk) begin
    if (alu_add)      alu_c <= {{32{alu_a[31]}}, alu_a} + {{32{alu_b[31]}}, alu_b};
    else if (alu_sub) alu_c <= {{32{alu_a[31]}}, alu_a} - {{32{alu_b[31]}}, alu_b};
    else if (alu_mul) alu_c <= {32'd0, alu_a} * {32'd0, alu_b};
    else if (alu_div) alu_c <= (alu_b == 0) ? 64'd0 : {alu_a % alu_b, alu_a / alu_b};
    else if (alu_and) alu_c <= {32'd0, alu_a & alu_b};
    else if (alu_or)  alu_c <= {32'd0, alu_a | alu_b};
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Issue one request and follow it until rsp_valid (or a 40-cycle bound).
  task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        output int lat, output int hi_op, output int hi_any,
                        output int multi, output logic [31:0] seen_a);
    int cyc;
    @(negedge clk);
    req_valid = 1'b1; req_op = op; req_a = a; req_b = b;
    @(posedge clk);
    #1;
    req_valid = 1'b0; req_a = 32'hDEADBEEF; req_b = 32'hCAFEF00D; req_op = 4'd0;
    cyc = 0; hi_op = 0; hi_any = 0; multi = 0; seen_a = '0;
    while (cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) seen_a = alu_a;
      if ($countones(stb) > 1) multi++;
      if (stb != 0) hi_any++;
      if (op < 4'd13 && stb[op]) hi_op++;
      if (rsp_valid) break;
    end
    lat = cyc;
  endtask

  task automatic handshake();
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
  endtask

  initial begin
    int lat, hi_op, hi_any, multi, bad;
    logic [31:0] seen_a;

    // Reset state
    #2;
    chk("reset_outputs", {19'd0, stb, rsp_valid, req_ready, rsp_err, alu_a}, 64'd0);
    chk("reset_z", {z_hi, z_lo}, 64'd0);
    @(negedge clk);
    clr_n = 1'b1;
    #1;
    chk("ready_after_release", {63'd0, req_ready}, 64'd1);

    // Reset asserted in the middle of MUL EXEC
    @(negedge clk);
    req_valid = 1'b1; req_op = 4'd4; req_a = 32'h10000; req_b = 32'h10000;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("mul_in_exec", {63'd0, alu_mul}, 64'd1);
    #2;
    clr_n = 1'b0;
    #1;
    chk("midreset_ctrl", {19'd0, stb, rsp_valid, req_ready, rsp_err, alu_a}, 64'd0);
    chk("midreset_data", {alu_b, z_lo | z_hi}, 64'd0);
    @(negedge clk);
    clr_n = 1'b1;
    #1;
    chk("midreset_ready", {63'd0, req_ready}, 64'd1);
    bad = 0;
    repeat (8) begin
      @(negedge clk);
      if (stb != 0 || rsp_valid) bad++;
    end
    chk("midreset_no_capture", {z_hi, z_lo}, 64'd0);
    chk("midreset_quiet", bad, 0);

    // ADD 5 + 7
    run_op(4'd2, 32'd5, 32'd7, lat, hi_op, hi_any, multi, seen_a);
    chk("add_latency", lat, 3);
    chk("add_strobe_cycles", {hi_op, hi_any}, {32'd1, 32'd1});
    chk("add_operand_latched", seen_a, 32'd5);
    chk("add_alu_b_held", alu_b, 32'd7);
    chk("add_result", {z_hi, z_lo}, 64'd12);
    chk("add_err", {63'd0, rsp_err}, 64'd0);
    handshake();
    @(negedge clk);
    chk("add_back_idle", {62'd0, req_ready, rsp_valid}, 64'd2);

    // SUB 3 - 5 with rsp_ready already high
    rsp_ready = 1'b1;
    run_op(4'd3, 32'd3, 32'd5, lat, hi_op, hi_any, multi, seen_a);
    chk("sub_latency", lat, 3);
    chk("sub_result", {z_hi, z_lo}, 64'hFFFFFFFF_FFFFFFFE);
    chk("sub_err", {63'd0, rsp_err}, 64'd0);
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("sub_early_ready_idle", {62'd0, req_ready, rsp_valid}, 64'd2);

    // MUL 0x10000 * 0x10000
    run_op(4'd4, 32'h10000, 32'h10000, lat, hi_op, hi_any, multi, seen_a);
    chk("mul_latency", lat, 6);
    chk("mul_strobe_cycles", {hi_op, hi_any}, {32'd4, 32'd4});
    chk("mul_multihot", multi, 0);
    chk("mul_result", {z_hi, z_lo}, 64'h00000001_00000000);
    handshake();

    // Illegal opcode 14
    run_op(4'd14, 32'h1234, 32'h5678, lat, hi_op, hi_any, multi, seen_a);
    chk("illegal_latency", lat, 1);
    chk("illegal_no_strobe", hi_any, 0);
    chk("illegal_err", {63'd0, rsp_err}, 64'd1);
    chk("illegal_result", {z_hi, z_lo}, 64'd0);
    handshake();
    @(negedge clk);
    chk("illegal_z_kept", {31'd0, rsp_err, z_hi | z_lo}, 64'h1_00000000);

    // DIV 17 / 5 under backpressure
    run_op(4'd5, 32'd17, 32'd5, lat, hi_op, hi_any, multi, seen_a);
    chk("div_latency", lat, 6);
    chk("div_strobe_cycles", {hi_op, hi_any}, {32'd4, 32'd4});
    chk("div_result", {z_hi, z_lo}, {32'd2, 32'd3});
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      req_valid = ~req_valid;
      req_op = 4'(i);
      @(negedge clk);
      if ({z_hi, z_lo} !== {32'd2, 32'd3} || req_ready !== 1'b0 || stb !== 13'd0 ||
          rsp_valid !== 1'b1 || rsp_err !== 1'b0)
        bad++;
    end
    chk("div_backpressure_stable", bad, 0);
    req_valid = 1'b0;
    handshake();
    @(negedge clk);
    chk("div_back_idle", {62'd0, req_ready, rsp_valid}, 64'd2);
    repeat (3) @(negedge clk);
    chk("div_z_kept", {z_hi, z_lo}, {32'd2, 32'd3});

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
